// File: rtl/riscv_cpu_pkg.sv
// Shared CPU-side types for the instruction-memory responder.
package riscv_cpu_pkg;

  localparam int          INSTR_MEM_MAX_LATENCY = 4;
  localparam logic [31:0] IMEM_ERR_RDATA        = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_resp_t;

endpackage

// File: rtl/instr_mem_responder_resp_pipe.sv
// Fixed-latency response delay line; the last stage drives the fetch response outputs.
module instr_resp_pipe
  import riscv_cpu_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  imem_resp_t resp_i,
  output imem_resp_t resp_o
);

  imem_resp_t r_stage [LATENCY];
  imem_resp_t w_next  [LATENCY];

  // Next value per stage; a flush kills everything already in the line but not the new entry
  always_comb begin
    w_next[0] = resp_i;
    for (int i = 1; i < LATENCY; i++) begin
      w_next[i] = r_stage[i-1];
      if (flush_i) begin
        w_next[i].valid = 1'b0;
      end else begin
        w_next[i].valid = r_stage[i-1].valid;
      end
    end
  end

  // Shift register; the output stage only takes payload from a live response so rdata/err hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '{valid: 1'b0, err: 1'b0, data: 32'h0000_0000};
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i].valid <= w_next[i].valid;
        if ((i != LATENCY - 1) || w_next[i].valid) begin
          r_stage[i].err  <= w_next[i].err;
          r_stage[i].data <= w_next[i].data;
        end else begin
          r_stage[i].err  <= r_stage[i].err;
          r_stage[i].data <= r_stage[i].data;
        end
      end
    end
  end

  assign resp_o = r_stage[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: program array, address decode, grant and outstanding tracking.
// Optional build macro INSTR_MEM_STATS_EN adds accepted-request and stall counters.
module instr_mem_responder
  import riscv_cpu_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         flush_i,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_data_i
`ifdef INSTR_MEM_STATS_EN
  ,
  output logic [31:0]                  stat_req_o,
  output logic [31:0]                  stat_stall_o
`endif
);

  localparam int            AW          = $clog2(MEM_WORDS);
  localparam int            CW          = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]   MEM_WORDS_W = 32'(MEM_WORDS);

  logic [31:0]   r_mem [MEM_WORDS];
  logic [CW-1:0] r_outstanding;
  logic [31:0]   w_offset;
  logic [31:0]   w_word_idx;
  logic          w_addr_err;
  logic          w_gnt;
  logic          w_accept;
  imem_resp_t    w_resp_in;
  imem_resp_t    w_resp_out;

  // Addresses below the base wrap to huge offsets, so the range check catches them as well
  assign w_offset   = instr_addr_i - BASE_ADDR;
  assign w_word_idx = w_offset >> 2;
  assign w_addr_err = (instr_addr_i[1:0] != 2'b00) | (instr_addr_i < BASE_ADDR) |
                      (w_word_idx >= MEM_WORDS_W);

  assign w_gnt       = instr_req_i & ~load_we_i & ~rst_i & (r_outstanding < MAX_CNT);
  assign w_accept    = w_gnt;
  assign instr_gnt_o = w_gnt;

  // Program-load write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      r_mem[load_addr_i] <= load_data_i;
    end else begin
      r_mem[load_addr_i] <= r_mem[load_addr_i];
    end
  end

  // Response entering stage 1; captured by the pipe at the edge, giving a synchronous read
  always_comb begin
    w_resp_in.valid = w_accept;
    w_resp_in.err   = w_addr_err;
    if (w_addr_err) begin
      w_resp_in.data = IMEM_ERR_RDATA;
    end else begin
      w_resp_in.data = r_mem[w_word_idx[AW-1:0]];
    end
  end

  instr_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .resp_i  (w_resp_in),
    .resp_o  (w_resp_out)
  );

  // Granted-but-unanswered count; a flush leaves only a same-cycle accept outstanding
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outstanding <= {CW{1'b0}};
    end else if (flush_i) begin
      r_outstanding <= w_accept ? CW'(1) : {CW{1'b0}};
    end else begin
      case ({w_accept, w_resp_out.valid})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign instr_rvalid_o = w_resp_out.valid;
  assign instr_rdata_o  = w_resp_out.data;
  assign instr_err_o    = w_resp_out.err;

`ifdef INSTR_MEM_STATS_EN
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_stall;

  // Saturating activity counters, independent of flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_req   <= 32'h0000_0000;
      r_stat_stall <= 32'h0000_0000;
    end else begin
      if (w_accept && (r_stat_req != 32'hFFFF_FFFF)) begin
        r_stat_req <= r_stat_req + 32'h0000_0001;
      end else begin
        r_stat_req <= r_stat_req;
      end
      if (instr_req_i && !w_gnt && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'h0000_0001;
      end else begin
        r_stat_stall <= r_stat_stall;
      end
    end
  end

  assign stat_req_o   = r_stat_req;
  assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Random plus directed bench for instr_mem_responder: two instances (LATENCY 2 and 1) share stimulus.
module tb_instr_mem_responder;

  localparam int MW = 64;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        flush;
  logic        we;
  logic [5:0]  la;
  logic [31:0] ld;
  logic        gnt [2];
  logic        rv  [2];
  logic [31:0] rd  [2];
  logic        er  [2];
`ifdef INSTR_MEM_STATS_EN
  logic [31:0] st_req   [2];
  logic [31:0] st_stall [2];
  logic [31:0] snap;
`endif

  int n_err = 0;
  int n_chk = 0;

  instr_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0000_0000), .LATENCY(2), .MAX_OUTSTANDING(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]), .instr_err_o(er[0]),
    .flush_i(flush), .load_we_i(we), .load_addr_i(la), .load_data_i(ld)
`ifdef INSTR_MEM_STATS_EN
    , .stat_req_o(st_req[0]), .stat_stall_o(st_stall[0])
`endif
  );

  instr_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0000_0100), .LATENCY(1), .MAX_OUTSTANDING(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]), .instr_err_o(er[1]),
    .flush_i(flush), .load_we_i(we), .load_addr_i(la), .load_data_i(ld)
`ifdef INSTR_MEM_STATS_EN
    , .stat_req_o(st_req[1]), .stat_stall_o(st_stall[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int max_of(input int d);
    return 2;
  endfunction
  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_0100;
  endfunction
  function automatic logic [31:0] w(input logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: a calendar of expected responses indexed by due cycle
  logic        exp_v [2][8];
  logic [31:0] exp_d [2][8];
  logic        exp_e [2][8];
  logic [31:0] last_d [2];
  logic        last_e [2];
  logic [31:0] mem_m [MW];
  int          cyc = 0;
  bit          started = 1'b0;
  int          m_outs, m_cur, m_slot;
  logic        m_eg, m_ev, m_aerr;
  logic [31:0] m_off;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) exp_v[d][k] = 1'b0;
      last_d[d] = 32'h0;
      last_e[d] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_cur  = cyc % 8;
      m_outs = 0;
      for (int k = 0; k < 8; k++) if (exp_v[d][k]) m_outs++;
      m_eg = !rst && req && !we && (m_outs < max_of(d));
      m_ev = exp_v[d][m_cur];
      if (m_ev) begin
        last_d[d] = exp_d[d][m_cur];
        last_e[d] = exp_e[d][m_cur];
      end
      if (started) begin
        chk("gnt", d, w(gnt[d]), w(m_eg));
        chk("rvalid", d, w(rv[d]), w(m_ev));
        chk("rdata", d, rd[d], last_d[d]);
        chk("err", d, w(er[d]), w(last_e[d]));
      end
      exp_v[d][m_cur] = 1'b0;
      if (rst) begin
        for (int k = 0; k < 8; k++) exp_v[d][k] = 1'b0;
        last_d[d] = 32'h0;
        last_e[d] = 1'b0;
      end else begin
        if (flush) for (int k = 0; k < 8; k++) exp_v[d][k] = 1'b0;
        if (m_eg) begin
          m_off  = addr - base_of(d);
          m_aerr = (addr[1:0] != 2'b00) || (addr < base_of(d)) || ((m_off >> 2) >= 32'(MW));
          m_slot = (cyc + lat_of(d)) % 8;
          exp_v[d][m_slot] = 1'b1;
          exp_e[d][m_slot] = m_aerr;
          if (m_aerr) exp_d[d][m_slot] = 32'h0;
          else        exp_d[d][m_slot] = mem_m[int'(m_off >> 2)];
        end
      end
    end
    if (we) mem_m[la] = ld;
    if (rst) started = 1'b1;
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; flush = 1'b0; we = 1'b0; rst = 1'b0;
    repeat (n) nxt();
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113; prog[3] = 32'h0030_0193;
    rst = 1'b1; req = 1'b0; addr = 32'h0; flush = 1'b0; we = 1'b0; la = 6'd0; ld = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gnt", 0, w(gnt[0]), 32'h0);
    chk("reset rvalid", 0, w(rv[0]), 32'h0);
    chk("reset rdata", 0, rd[0], 32'h0);
    rst = 1'b0;
    for (int i = 0; i < MW; i++) begin
      we = 1'b1; la = 6'(i);
      ld = (i < 4) ? prog[i] : $urandom;
      nxt();
    end
    idle(4);

    // Back-to-back fetch with MAX_OUTSTANDING=2, LATENCY=2
    req = 1'b1; addr = 32'h0; #3 chk("A gnt c0", 0, w(gnt[0]), 32'h1); nxt();
    addr = 32'h4; #3 chk("A gnt c1", 0, w(gnt[0]), 32'h1); nxt();
    addr = 32'h8; #3 chk("A gnt c2", 0, w(gnt[0]), 32'h0);
    chk("A rv c2", 0, w(rv[0]), 32'h1); chk("A rd c2", 0, rd[0], 32'h0000_0013); nxt();
    #3 chk("A gnt c3", 0, w(gnt[0]), 32'h1);
    chk("A rd c3", 0, rd[0], 32'h0010_0093); nxt();
    req = 1'b0; #3 chk("A rv c4", 0, w(rv[0]), 32'h0); nxt();
    #3 chk("A rv c5", 0, w(rv[0]), 32'h1); chk("A rd c5", 0, rd[0], 32'h0020_0113);
    chk("A err c5", 0, w(er[0]), 32'h0); nxt();
    idle(4);

    // Misaligned and out-of-range addresses
    req = 1'b1; addr = 32'h6; #3 chk("B gnt mis", 0, w(gnt[0]), 32'h1); nxt();
    addr = 32'h100; #3 chk("B gnt oor", 0, w(gnt[0]), 32'h1); nxt();
    req = 1'b0; #3 chk("B err mis", 0, w(er[0]), 32'h1); chk("B rd mis", 0, rd[0], 32'h0); nxt();
    #3 chk("B rv oor", 0, w(rv[0]), 32'h1); chk("B err oor", 0, w(er[0]), 32'h1); nxt();
    idle(4);

    // Flush with a same-cycle accept
    req = 1'b1; addr = 32'h0; nxt();
    addr = 32'h4; nxt();
    addr = 32'h8; nxt();
    flush = 1'b1; #3 chk("C gnt flush", 0, w(gnt[0]), 32'h1);
    chk("C rd flush", 0, rd[0], 32'h0010_0093); nxt();
    flush = 1'b0; req = 1'b0; #3 chk("C rv c4", 0, w(rv[0]), 32'h0); nxt();
    #3 chk("C rv c5", 0, w(rv[0]), 32'h1); chk("C rd c5", 0, rd[0], 32'h0020_0113); nxt();
    req = 1'b1; addr = 32'h0; #3 chk("C rv c6", 0, w(rv[0]), 32'h0);
    chk("C gnt c6", 0, w(gnt[0]), 32'h1); nxt();
    addr = 32'h4; #3 chk("C gnt c7", 0, w(gnt[0]), 32'h1); nxt();
    idle(4);

    // Program load stalls the fetch port
    req = 1'b1; addr = 32'h14; we = 1'b1; la = 6'd5; ld = 32'hDEAD_BEEF;
    #3 chk("D gnt c0", 0, w(gnt[0]), 32'h0);
`ifdef INSTR_MEM_STATS_EN
    snap = st_stall[0];
`endif
    nxt();
    #3 chk("D gnt c1", 0, w(gnt[0]), 32'h0); nxt();
    #3 chk("D gnt c2", 0, w(gnt[0]), 32'h0); nxt();
    we = 1'b0; #3 chk("D gnt c3", 0, w(gnt[0]), 32'h1);
`ifdef INSTR_MEM_STATS_EN
    chk("D stat_stall", 0, st_stall[0] - snap, 32'h3);
    snap = st_req[0];
`endif
    nxt();
    req = 1'b0;
`ifdef INSTR_MEM_STATS_EN
    #3 chk("D stat_req", 0, st_req[0] - snap, 32'h1);
`endif
    nxt();
    #3 chk("D rd new", 0, rd[0], 32'hDEAD_BEEF); nxt();
    idle(4);

    // Reset with requests in flight
    req = 1'b1; addr = 32'h0; nxt();
    addr = 32'h4; nxt();
    rst = 1'b1; addr = 32'h8; #3 chk("E gnt rst", 0, w(gnt[0]), 32'h0);
    chk("E gnt rst", 1, w(gnt[1]), 32'h0); nxt();
    rst = 1'b0; req = 1'b0; #3 chk("E rv c3", 0, w(rv[0]), 32'h0); nxt();
    #3 chk("E rv c4", 0, w(rv[0]), 32'h0); nxt();
    req = 1'b1; #3 chk("E gnt c5", 0, w(gnt[0]), 32'h1); nxt();
    req = 1'b0; nxt();
    #3 chk("E rd c7", 0, rd[0], 32'h0020_0113); nxt();
    idle(4);

    // LATENCY=1 instance under continuous requests
    for (int i = 0; i < 5; i++) begin
      req = (i < 4); addr = 32'h100 + 32'(4 * i);
      #3;
      if (i < 4) chk("F gnt", 1, w(gnt[1]), 32'h1);
      if (i > 0) chk("F rd", 1, rd[1], prog[i-1]);
      nxt();
    end
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      req   = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      we    = ($urandom_range(0, 9) == 0);
      la    = 6'($urandom_range(0, MW - 1));
      ld    = $urandom;
      case ($urandom_range(0, 4))
        0, 1, 2: addr = 32'($urandom_range(0, 255)) << 2;
        3:       addr = 32'($urandom_range(0, 1023));
        default: addr = $urandom;
      endcase
      nxt();
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
